// File: rtl/trivium_uart_pkg.sv
// Shared definitions for the Trivium UART transmit and receive stages.
// Contents: TX FSM state encoding, data bits per byte, bit times per 8N1 frame.
package trivium_uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/trivium_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational read port.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (pointers only)
//   push, wdata     write request and data; ignored when full unless a pop
//                   happens on the same edge
//   pop, rdata      read request and head-of-queue data; ignored when empty
//   full, empty     occupancy flags derived from registered pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra wrap bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        // A pop frees the slot the push needs, so push-when-full succeeds then.
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/trivium_uart_tx.sv
// trivium_uart_tx: packs the Trivium output bit stream LSB-first into bytes,
// queues them in a small FIFO and sends each byte as an 8N1 UART frame.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bit_in, bit_valid one ciphertext bit per accepted cycle
//   flush             push any partial byte (zero padded) and request done
//   tx                registered serial line, idles high
//   busy              FSM active or FIFO non-empty
//   fifo_full         FIFO holds FIFO_DEPTH bytes
//   overflow          sticky: a byte was dropped on a full FIFO
//   done              one-cycle pulse once a flush has fully drained
module trivium_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic flush,
    output logic tx,
    output logic busy,
    output logic fifo_full,
    output logic overflow,
    output logic done
);

    import trivium_uart_pkg::*;

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    tx_state_t            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] tx_sr_q, tx_sr_d;
    logic                 tx_q, tx_d;
    logic                 overflow_q, overflow_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 done_q, done_d;

    logic [DATA_BITS-1:0] packed_byte;
    logic [3:0]           cnt_inc;
    logic                 push;
    logic                 pop;
    logic                 baud_last;
    logic                 done_cond;
    logic [DATA_BITS-1:0] rdata;
    logic                 full;
    logic                 empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (packed_byte),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        // Packer: the current bit joins the byte before any push decision, so
        // flush together with the 8th bit yields exactly one push. The shift
        // register is cleared on every push, which gives the zero padding.
        packed_byte = sr_q;
        if (bit_valid) begin
            packed_byte[bit_cnt_q] = bit_in;
        end
        cnt_inc = {1'b0, bit_cnt_q} + {3'b000, bit_valid};
        push    = (cnt_inc == 4'd8) || (flush && (cnt_inc != 4'd0));
        if (push) begin
            sr_d      = '0;
            bit_cnt_d = '0;
        end else begin
            sr_d      = packed_byte;
            bit_cnt_d = cnt_inc[2:0];
        end

        // TX FSM
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        tx_sr_d   = tx_sr_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    tx_sr_d = rdata;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = tx_sr_q[0];
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift first, so the next bit sits at index 1 now.
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_sr_d   = tx_sr_q >> 1;
                        tx_d      = tx_sr_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Back-to-back frames: go straight to START with no idle bit.
                    if (!empty) begin
                        pop     = 1'b1;
                        tx_sr_d = rdata;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush completion: a new flush in the same cycle keeps the request alive.
        done_cond    = flush_pend_q && empty && (state_q == IDLE) && (bit_cnt_q == 3'd0);
        done_d       = done_cond;
        flush_pend_d = flush || (flush_pend_q && !done_cond);
        overflow_d   = overflow_q || (push && full && !pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            state_q      <= IDLE;
            baud_q       <= '0;
            bit_idx_q    <= '0;
            tx_sr_q      <= '0;
            tx_q         <= 1'b1;
            overflow_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            tx_sr_q      <= tx_sr_d;
            tx_q         <= tx_d;
            overflow_q   <= overflow_d;
            flush_pend_q <= flush_pend_d;
            done_q       <= done_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != IDLE) || !empty;
    assign fifo_full = full;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_trivium_uart_tx.sv
// Directed bench for trivium_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_trivium_uart_tx;

    logic clk;
    logic rst;
    logic bit_in;
    logic bit_valid;
    logic flush;
    logic tx;
    logic busy;
    logic fifo_full;
    logic overflow;
    logic done;

    int tests;
    int fails;

    logic [39:0]  cap40;
    logic [199:0] cap200;
    logic [199:0] exp200;
    logic [47:0]  stream;

    trivium_uart_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .flush     (flush),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %b, expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [199:0] obs, input logic [199:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    // Expected per-cycle tx samples of one frame at 4 clocks per bit, bit 0 first.
    function automatic logic [39:0] frame(input logic [7:0] b);
        logic [39:0] v;
        logic        bv;
        v = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      bv = 1'b0;
            else if (i == 9) bv = 1'b1;
            else             bv = b[i-1];
            v[i*4 +: 4] = {4{bv}};
        end
        return v;
    endfunction

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bit_in    = b[i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic capture(output logic [39:0] v);
        for (int i = 0; i < 40; i++) begin
            v[i] = tx;
            tick();
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_full", fifo_full, 1'b0);
        chk("reset_ovf", overflow, 1'b0);
        chk("reset_done", done, 1'b0);
        rst = 1'b0;
        tick();

        // Single byte 0xA5
        send_bits(8'hA5, 8);
        chk("a5_tx_before_pop", tx, 1'b1);
        chk("a5_busy", busy, 1'b1);
        tick();
        capture(cap40);
        chk_vec("a5_frame", {160'b0, cap40}, {160'b0, frame(8'hA5)});
        chk("a5_idle_tx", tx, 1'b1);
        chk("a5_idle_busy", busy, 1'b0);
        chk("a5_no_done", done, 1'b0);

        // Partial byte 1,1,0 then flush
        send_bits(8'h03, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl3_tx_before_pop", tx, 1'b1);
        chk("fl3_done_early", done, 1'b0);
        tick();
        capture(cap40);
        chk_vec("fl3_frame", {160'b0, cap40}, {160'b0, frame(8'h03)});
        chk("fl3_done_at_stop_end", done, 1'b0);
        chk("fl3_busy_low", busy, 1'b0);
        tick();
        chk("fl3_done_pulse", done, 1'b1);
        tick();
        chk("fl3_done_clear", done, 1'b0);

        // Flush with nothing pending
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl0_done_early", done, 1'b0);
        chk("fl0_tx", tx, 1'b1);
        tick();
        chk("fl0_done_pulse", done, 1'b1);
        chk("fl0_busy", busy, 1'b0);
        tick();
        chk("fl0_done_clear", done, 1'b0);
        chk("fl0_no_frame", tx, 1'b1);

        // Flush together with the 8th bit of 0xC3
        send_bits(8'hC3, 7);
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        flush     = 1'b1;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        flush     = 1'b0;
        chk("fl8_tx_before_pop", tx, 1'b1);
        tick();
        capture(cap40);
        chk_vec("fl8_frame", {160'b0, cap40}, {160'b0, frame(8'hC3)});
        chk("fl8_no_extra_tx", tx, 1'b1);
        chk("fl8_no_extra_busy", busy, 1'b0);
        tick();
        chk("fl8_done_pulse", done, 1'b1);
        tick();

        // 48 consecutive bits: bytes 0x11..0x66, 0x66 must be dropped
        stream = 48'h665544332211;
        exp200 = {frame(8'h55), frame(8'h44), frame(8'h33), frame(8'h22), frame(8'h11)};
        cap200 = '0;
        for (int c = 1; c <= 210; c++) begin
            if (c <= 48) begin
                bit_valid = 1'b1;
                bit_in    = stream[c-1];
            end else begin
                bit_valid = 1'b0;
                bit_in    = 1'b0;
            end
            tick();
            if (c >= 9 && c <= 208) cap200[c-9] = tx;
            if (c == 39) chk("burst_not_full_3", fifo_full, 1'b0);
            if (c == 40) chk("burst_full_4", fifo_full, 1'b1);
            if (c == 47) chk("burst_ovf_before", overflow, 1'b0);
            if (c == 48) chk("burst_ovf_at_6th", overflow, 1'b1);
            if (c == 209) begin
                chk("burst_idle_tx", tx, 1'b1);
                chk("burst_idle_busy", busy, 1'b0);
            end
        end
        chk_vec("burst_5_frames", cap200, exp200);
        chk("burst_ovf_sticky", overflow, 1'b1);

        // Reset during DATA with a second byte queued
        send_bits(8'h00, 8);
        tick();
        send_bits(8'h77, 8);
        chk("mid_tx_low", tx, 1'b0);
        chk("mid_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_full", fifo_full, 1'b0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_tx", tx, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
        send_bits(8'h5A, 8);
        tick();
        capture(cap40);
        chk_vec("post_rst_5a_frame", {160'b0, cap40}, {160'b0, frame(8'h5A)});
        chk("post_rst_idle_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
